// File: rtl/tmds_decoder.sv
// Purpose: TMDS receive channel decoder; hunts control tokens for word alignment, then decodes video/control.
// Latency: 2 cycles from the word completing in the window to o_data/o_control/o_ve once locked.
// Backpressure: none; one word accepted every pixel clock, outputs are free-running.
module tmds_decoder #(
   parameter int LOCK_COUNT = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_word,
   output logic [7:0] o_data,
   output logic [1:0] o_control,
   output logic       o_ve,
   output logic       o_locked,
   output logic       o_err
);

   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   function automatic logic is_token(input logic [9:0] w);
      return (w == 10'b1101010100) || (w == 10'b0010101011) ||
             (w == 10'b0101010100) || (w == 10'b1010101011);
   endfunction

   function automatic logic [1:0] token_val(input logic [9:0] w);
      logic [1:0] v;
      v = 2'b00;
      case (w)
         10'b0010101011: v = 2'b01;
         10'b0101010100: v = 2'b10;
         10'b1010101011: v = 2'b11;
         default:        v = 2'b00;
      endcase
      return v;
   endfunction

   // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
   function automatic logic [7:0] decode_video(input logic [9:0] w);
      logic [7:0] d;
      logic [7:0] o;
      d    = w[9] ? ~w[7:0] : w[7:0];
      o    = 8'h00;
      o[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return o;
   endfunction

   state_t        state_q, state_d;
   logic [9:0]    prev_q, prev_d;
   logic [3:0]    c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    offset_q, offset_d;
   logic [9:0]    w_q, w_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          ve_q, ve_d;
   logic          locked_q, locked_d;
   logic          err_q, err_d;

   logic [19:0]   window;
   logic [9:0]    cand [10];
   logic [9:0]    tok_hit;
   logic          any_hit;
   logic [3:0]    first_hit;
   logic [TW-1:0] tcnt_inc;

   // All candidate alignments of the 20-bit window, and the lowest offset carrying a token.
   always_comb begin
      window    = {i_word, prev_q};
      tok_hit   = '0;
      first_hit = 4'd0;
      for (int k = 0; k < 10; k++) begin
         cand[k]    = window[k +: 10];
         tok_hit[k] = is_token(window[k +: 10]);
      end
      for (int k = 9; k >= 0; k--) begin
         if (tok_hit[k]) first_hit = 4'(k);
      end
      any_hit = |tok_hit;
   end

   // State register and all pipeline/counter flops; async reset clears outputs at once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= SEARCH;
         prev_q   <= '0;
         c_q      <= '0;
         cnt_q    <= '0;
         offset_q <= '0;
         w_q      <= '0;
         tcnt_q   <= '0;
         data_q   <= '0;
         ctrl_q   <= '0;
         ve_q     <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         offset_q <= offset_d;
         w_q      <= w_d;
         tcnt_q   <= tcnt_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         ve_q     <= ve_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   // Next-state: token hunting in SEARCH, decode and timeout supervision in LOCKED.
   always_comb begin
      state_d  = state_q;
      prev_d   = i_word;
      c_d      = c_q;
      cnt_d    = cnt_q;
      offset_d = offset_q;
      tcnt_d   = tcnt_q;
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      ve_d     = ve_q;
      locked_d = locked_q;
      err_d    = 1'b0;
      tcnt_inc = (tcnt_q < TW'(TIMEOUT)) ? tcnt_q + TW'(1) : tcnt_q;
      // Stage 1 follows the tracked candidate while searching so the first locked word is already aligned.
      w_d      = (state_q == LOCKED) ? cand[offset_q] : cand[c_q];

      case (state_q)
         SEARCH: begin
            data_d = 8'h00;
            ctrl_d = 2'b00;
            ve_d   = 1'b0;
            if (tok_hit[c_q]) begin
               cnt_d = cnt_q + CW'(1);
            end else if (any_hit) begin
               c_d   = first_hit;
               cnt_d = CW'(1);
            end else begin
               cnt_d = '0;
            end
            if (cnt_d == CW'(LOCK_COUNT)) begin
               state_d  = LOCKED;
               offset_d = c_d;
               locked_d = 1'b1;
               tcnt_d   = '0;
            end
         end
         LOCKED: begin
            if (is_token(w_q)) begin
               ctrl_d = token_val(w_q);
               ve_d   = 1'b0;
               tcnt_d = '0;
            end else begin
               data_d = decode_video(w_q);
               ve_d   = 1'b1;
               tcnt_d = tcnt_inc;
               if (tcnt_inc == TW'(TIMEOUT)) begin
                  state_d  = SEARCH;
                  locked_d = 1'b0;
                  err_d    = 1'b1;
                  cnt_d    = '0;
                  c_d      = offset_q;
                  ve_d     = 1'b0;
                  data_d   = 8'h00;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // Outputs come straight from flops.
   always_comb begin
      o_data    = data_q;
      o_control = ctrl_q;
      o_ve      = ve_q;
      o_locked  = locked_q;
      o_err     = err_q;
   end

endmodule

// File: tb/tb_tmds_decoder.sv
// Purpose: directed self-checking bench for tmds_decoder (lock, rotation, decode, timeout, reset).
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: none; one word per clock.
module tb_tmds_decoder;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [9:0] i_word;
   logic [7:0] o_data;
   logic [1:0] o_control;
   logic       o_ve;
   logic       o_locked;
   logic       o_err;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] D00 = 10'b0100000000;
   localparam logic [9:0] DFE = 10'b1011111111;

   int         errors = 0;
   int         checks = 0;
   logic [9:0] prev_sym;

   tmds_decoder #(.LOCK_COUNT(8), .TIMEOUT(16)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_word    (i_word),
      .o_data    (o_data),
      .o_control (o_control),
      .o_ve      (o_ve),
      .o_locked  (o_locked),
      .o_err     (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [9:0] w);
      i_word = w;
      @(negedge i_clk);
   endtask

   // Place symbol s at bit offset k of the serial stream.
   task automatic send_sym(input logic [9:0] s, input int k);
      logic [19:0] pair;
      pair     = {s, prev_sym};
      pair     = pair >> (10 - k);
      prev_sym = s;
      send(pair[9:0]);
   endtask

   task automatic do_reset();
      i_rst    = 1'b1;
      i_word   = '0;
      prev_sym = '0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      i_rst    = 1'b1;
      i_word   = '0;
      prev_sym = '0;
      #1;
      check("rst_locked", o_locked, 0);
      check("rst_ve", o_ve, 0);
      check("rst_data", o_data, 0);
      check("rst_ctrl", o_control, 0);
      check("rst_err", o_err, 0);

      // Lock at offset 0, then a video word
      do_reset();
      repeat (8) send(T00);
      check("t1_not_yet", o_locked, 0);
      send(D00);
      check("t1_locked", o_locked, 1);
      send(T00);
      check("t1_ctrl", o_control, 0);
      check("t1_ve0", o_ve, 0);
      send(T00);
      check("t1_ve1", o_ve, 1);
      check("t1_data", o_data, 8'h00);
      send(T00);
      check("t1_ve_back", o_ve, 0);

      // Lock at offset 3
      do_reset();
      repeat (8) send_sym(T00, 3);
      check("t2_not_yet", o_locked, 0);
      send_sym(T00, 3);
      check("t2_locked", o_locked, 1);
      send_sym(DFE, 3);
      send_sym(T00, 3);
      send_sym(T00, 3);
      check("t2_data", o_data, 8'hFE);
      check("t2_ve", o_ve, 1);
      send_sym(T00, 3);
      check("t2_ve0", o_ve, 0);
      check("t2_hold", o_data, 8'hFE);

      // Control value sequence, data held through control period
      do_reset();
      repeat (9) send(T00);
      check("t3_locked", o_locked, 1);
      send(DFE);
      send(T11);
      send(T10);
      check("t3_data", o_data, 8'hFE);
      send(T01);
      check("t3_c11", o_control, 3);
      check("t3_ve_a", o_ve, 0);
      check("t3_hold", o_data, 8'hFE);
      send(T00);
      check("t3_c10", o_control, 2);
      check("t3_ve_b", o_ve, 0);
      send(T00);
      check("t3_c01", o_control, 1);
      check("t3_ve_c", o_ve, 0);
      send(T00);
      check("t3_c00", o_control, 0);

      // Interrupted run must restart the count
      do_reset();
      repeat (7) send(T00);
      send(D00);
      check("t4_after7", o_locked, 0);
      repeat (7) send(T00);
      check("t4_run2_7", o_locked, 0);
      send(T00);
      check("t4_run2_8", o_locked, 0);
      send(T00);
      check("t4_run2_lock", o_locked, 1);

      // Timeout with data only
      do_reset();
      repeat (12) send(T00);
      check("t5_locked", o_locked, 1);
      repeat (17) send(DFE);
      check("t5_still", o_locked, 1);
      check("t5_no_err", o_err, 0);
      check("t5_ve_on", o_ve, 1);
      send(DFE);
      check("t5_drop", o_locked, 0);
      check("t5_err", o_err, 1);
      check("t5_ve_off", o_ve, 0);
      check("t5_data0", o_data, 0);
      send(DFE);
      check("t5_err_pulse", o_err, 0);
      check("t5_ve_after", o_ve, 0);
      check("t5_unlocked", o_locked, 0);

      // Token at the last moment keeps lock
      repeat (10) send(T00);
      check("t5b_relock", o_locked, 1);
      repeat (15) send(DFE);
      send(T00);
      repeat (2) send(DFE);
      check("t5b_kept", o_locked, 1);
      check("t5b_no_err", o_err, 0);
      repeat (4) send(DFE);
      check("t5b_kept2", o_locked, 1);

      // Asynchronous reset mid-data
      check("t6_pre_ve", o_ve, 1);
      #2 i_rst = 1'b1;
      #1;
      check("t6_locked", o_locked, 0);
      check("t6_ve", o_ve, 0);
      check("t6_data", o_data, 0);
      check("t6_ctrl", o_control, 0);
      check("t6_err", o_err, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (8) send(T00);
      check("t6_not_yet", o_locked, 0);
      send(T00);
      check("t6_relock", o_locked, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
